p3_datapath: RTL and testbench
==============================

// Module: p3_datapath
// PURPOSE
//  16-bit RISC datapath: 8x16 register file, A/B operand registers, B-path shifter, ALU,
//  C result register and Z status flag. Write-back source is datapath_in or C.
//  Sits under the CPU controller, which drives all select/load/write strobes.
// PARAMETERS
//  DATA_W   16  datapath width; register-file depth is fixed at 8 (3-bit index)
// PORTS
//  clk           in   1       single clock; all state updates on rising edge
//  rst_n         in   1       asynchronous, active-low reset
//  datapath_in   in   DATA_W  external data: write-back source and immediate source
//  writenum      in   3       register-file write index
//  write         in   1       register-file write enable
//  readnum       in   3       register-file read index (combinational read)
//  loada         in   1       load A from the read port
//  loadb         in   1       load B from the read port
//  loadc         in   1       load C from the ALU output
//  loads         in   1       load Z from the ALU zero detect
//  asel          in   1       0: Ain=A; 1: Ain=0
//  bsel          in   1       0: Bin=shifted B; 1: Bin={11'b0, datapath_in[4:0]}
//  vsel          in   1       write-back data select, 0: C; 1: datapath_in
//  shift         in   2       shifter op applied to B
//  ALUop         in   2       ALU operation
//  datapath_out  out  DATA_W  C register
//  Z_out         out  1       Z status register
// BEHAVIOUR
//  - Reset (rst_n=0, async): R0-R7, A, B, C = 0; Z = 0. datapath_out=0, Z_out=0 immediately.
//  - Reg file: read data = R[readnum], combinational. On posedge with write=1,
//    R[writenum] <= (vsel ? datapath_in : C).
//  - Write and read of the same index in one cycle: read returns the old value until the edge.
//  - A/B: on posedge, A <= rd if loada; B <= rd if loadb. Both may load in one cycle.
//  - Shifter (on B): 00 pass; 01 B<<1, LSB=0; 10 B>>1, MSB=0; 11 B>>1, MSB kept (arithmetic).
//  - ALU (combinational, DATA_W bits, wrap-around, no carry out):
//    00 Ain+Bin; 01 Ain-Bin; 10 Ain&Bin; 11 ~Bin.
//  - On posedge: C <= ALU if loadc; Z <= (ALU==0) if loads. The Z flag is independent of loadc.
//  - Latency: register read -> A/B load 1 clk; -> C 1 clk more; -> write-back 1 clk more.
//  - write and loadc in the same cycle: write-back uses the pre-edge C.
//  - Unasserted loads hold their value. Reset mid-sequence discards all state.
// CONFIGURATION
//  STATUS_NV_EN defined: adds outputs N_out (ALU[MSB]) and V_out (signed overflow of
//   add/sub; 0 for AND/NOT). Both load with loads and reset to 0.
//  STATUS_NV_EN undefined: Z only. These ports and registers do not exist.
// STRUCTURE
//  - Package p3_datapath_pkg: ALU op encodings (ADD/SUB/AND/NOTB), shift encodings
//    (NONE/LSL/LSR/ASR), REG_IDX_W=3.
//  - Sub-module p3_regfile: 8xDATA_W, 1 sync write port, 1 async read port, async reset.
//  - Shifter, ALU, muxes and the A/B/C/status registers stay inline.
// TESTING
//  1 Add: write R0=5, R1=0xA (vsel=1); A<=R0, B<=R1; asel=bsel=0, shift=00, ALUop=00, loadc;
//    vsel=0 write R2 -> datapath_out=0x000F, R2=0x000F.
//  2 Sub: R3=0xF, R4=5; A<=R3, B<=R4; ALUop=01 -> C=0x000A; with loads, Z=0.
//    Then R4=0xF, B<=R4, ALUop=01, loads -> Z=1.
//  3 Shift: R6=0x1234, B<=R6; asel=1, shift=01, ALUop=00 -> C=0x2468. shift=10 -> 0x091A.
//    B=0x8000, shift=11 -> C=0xC000.
//  4 Immediate/logic: bsel=1, datapath_in=0xFFF3, asel=1, ALUop=00 -> C=0x0013.
//    ALUop=11 with B=0x00FF, bsel=0 -> C=0xFF00.
//  5 Reset: assert rst_n=0 mid-clock after test 1 -> datapath_out=0, Z_out=0 at once;
//    read of R2 returns 0.
//  6 Hold: loadc=0 while ALU inputs change -> datapath_out unchanged; write=0 -> R7 unchanged.

Source files
------------

// File: rtl/p3_datapath_pkg.sv
// p3_datapath_pkg: ALU/shift encodings and register index width shared by the datapath
package p3_datapath_pkg;
    localparam int REG_IDX_W = 3;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_NOTB = 2'b11} alu_op_e;
    typedef enum logic [1:0] {SH_NONE = 2'b00, SH_LSL = 2'b01, SH_LSR = 2'b10, SH_ASR = 2'b11} shift_e;
endpackage

// File: rtl/p3_datapath_if.sv
// p3_datapath_if: controller-to-datapath strobes and result bus; N_out/V_out exist only with STATUS_NV_EN
interface p3_datapath_if #(parameter int DATA_W = 16);
    import p3_datapath_pkg::*;
    logic [DATA_W-1:0]    datapath_in;
    logic [REG_IDX_W-1:0] writenum;
    logic                 write;
    logic [REG_IDX_W-1:0] readnum;
    logic                 loada;
    logic                 loadb;
    logic                 loadc;
    logic                 loads;
    logic                 asel;
    logic                 bsel;
    logic                 vsel;
    shift_e               shift;
    alu_op_e              ALUop;
    logic [DATA_W-1:0]    datapath_out;
    logic                 Z_out;
`ifdef STATUS_NV_EN
    logic                 N_out;
    logic                 V_out;
`endif
    modport master (
        output datapath_in, writenum, write, readnum, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop,
        input  datapath_out, Z_out
`ifdef STATUS_NV_EN
        , N_out, V_out
`endif
    );
    modport slave (
        input  datapath_in, writenum, write, readnum, loada, loadb, loadc, loads,
               asel, bsel, vsel, shift, ALUop,
        output datapath_out, Z_out
`ifdef STATUS_NV_EN
        , N_out, V_out
`endif
    );
endinterface

// File: rtl/p3_regfile.sv
// p3_regfile: 8 x DATA_W register file, one synchronous write port, one combinational read port
module p3_regfile
    import p3_datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic [DATA_W-1:0]    rd_data
);
    logic [2**REG_IDX_W-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;

    assign rd_data = regs_q[rd_idx];
endmodule

// File: rtl/p3_datapath.sv
// p3_datapath: regfile, A/B operands, B shifter, ALU, C result and status flags (N/V with STATUS_NV_EN)
module p3_datapath
    import p3_datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    p3_datapath_if.slave dp
);
    localparam int M = DATA_W - 1;
    logic [DATA_W-1:0] rd, sh, ain, bin, alu;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic              z_q, z_d;

    p3_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (dp.write),
        .wr_idx (dp.writenum),
        .wr_data(dp.vsel ? dp.datapath_in : c_q),
        .rd_idx (dp.readnum),
        .rd_data(rd)
    );

    always_comb begin
        sh  = dp.shift == SH_LSL ? {b_q[M-1:0], 1'b0} :
              dp.shift == SH_LSR ? {1'b0, b_q[M:1]} :
              dp.shift == SH_ASR ? {b_q[M], b_q[M:1]} : b_q;
        ain = dp.asel ? '0 : a_q;
        bin = dp.bsel ? DATA_W'(dp.datapath_in[4:0]) : sh;
        alu = dp.ALUop == ALU_ADD ? ain + bin :
              dp.ALUop == ALU_SUB ? ain - bin :
              dp.ALUop == ALU_AND ? ain & bin : ~bin;
        a_d = dp.loada ? rd : a_q;
        b_d = dp.loadb ? rd : b_q;
        c_d = dp.loadc ? alu : c_q;
        z_d = dp.loads ? (alu == '0) : z_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            z_q <= z_d;
        end

    assign dp.datapath_out = c_q;
    assign dp.Z_out        = z_q;

`ifdef STATUS_NV_EN
    logic n_q, n_d, v_q, v_d, ovf;

    always_comb begin
        ovf = dp.ALUop == ALU_ADD ? (ain[M] == bin[M]) && (alu[M] != ain[M]) :
              dp.ALUop == ALU_SUB ? (ain[M] != bin[M]) && (alu[M] != ain[M]) : 1'b0;
        n_d = dp.loads ? alu[M] : n_q;
        v_d = dp.loads ? ovf : v_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            n_q <= n_d;
            v_q <= v_d;
        end

    assign dp.N_out = n_q;
    assign dp.V_out = v_q;
`endif
endmodule

// File: tb/tb_p3_datapath.sv
// tb_p3_datapath: directed vectors checked against a behavioural datapath model every cycle
module tb_p3_datapath;
    import p3_datapath_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   cmp_en = 1'b0;

    p3_datapath_if #(.DATA_W(16)) bus ();
    p3_datapath #(.DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .dp(bus));

    always #5 clk = ~clk;

    int m_r [8];
    int m_a, m_b, m_c, m_z;

    function automatic int model_alu(input int a, input int b);
        int ai, bi, sb;
        sb = bus.shift == SH_LSL ? (b * 2) % 65536 :
             bus.shift == SH_LSR ? b / 2 :
             bus.shift == SH_ASR ? b / 2 + (b >= 32768 ? 32768 : 0) : b;
        ai = bus.asel ? 0 : a;
        bi = bus.bsel ? int'(bus.datapath_in) % 32 : sb;
        case (bus.ALUop)
            ALU_ADD: return (ai + bi) % 65536;
            ALU_SUB: return (ai - bi + 65536) % 65536;
            ALU_AND: return ai & bi;
            default: return 65535 - bi;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int rd, res, wb;
        if (!rst_n) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_a = 0; m_b = 0; m_c = 0; m_z = 0;
        end else begin
            rd  = m_r[bus.readnum];
            res = model_alu(m_a, m_b);
            wb  = bus.vsel ? int'(bus.datapath_in) : m_c;
            if (bus.write) m_r[bus.writenum] = wb;
            if (bus.loada) m_a = rd;
            if (bus.loadb) m_b = rd;
            if (bus.loadc) m_c = res;
            if (bus.loads) m_z = (res == 0) ? 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("cycle_c", bus.datapath_out, 16'(m_c));
            chk("cycle_z", {15'b0, bus.Z_out}, 16'(m_z));
        end
    end

    task automatic idle();
        bus.write = 0; bus.loada = 0; bus.loadb = 0; bus.loadc = 0; bus.loads = 0;
        bus.asel = 0; bus.bsel = 0; bus.vsel = 0; bus.shift = SH_NONE; bus.ALUop = ALU_ADD;
        bus.writenum = 0; bus.readnum = 0; bus.datapath_in = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr_imm(input int r, input logic [15:0] v);
        idle();
        bus.write = 1; bus.writenum = 3'(r); bus.vsel = 1; bus.datapath_in = v;
        step();
    endtask

    task automatic wr_c(input int r);
        idle();
        bus.write = 1; bus.writenum = 3'(r); bus.vsel = 0;
        step();
    endtask

    task automatic ld(input int r, input bit la, input bit lb);
        idle();
        bus.readnum = 3'(r); bus.loada = la; bus.loadb = lb;
        step();
    endtask

    task automatic op(input bit as, input bit bs, input shift_e sh, input alu_op_e al,
                      input bit lc, input bit ls, input logic [15:0] din);
        idle();
        bus.asel = as; bus.bsel = bs; bus.shift = sh; bus.ALUop = al;
        bus.loadc = lc; bus.loads = ls; bus.datapath_in = din;
        step();
    endtask

    task automatic rd_reg(input int r);
        ld(r, 1, 0);
        op(0, 1, SH_NONE, ALU_ADD, 1, 0, 16'h0);
    endtask

    task automatic test_add();
        wr_imm(0, 16'h0005);
        wr_imm(1, 16'h000A);
        ld(0, 1, 0);
        ld(1, 0, 1);
        op(0, 0, SH_NONE, ALU_ADD, 1, 0, 16'h0);
        chk("add_c", bus.datapath_out, 16'h000F);
        wr_c(2);
    endtask

    initial begin
        idle();
        #1;
        chk("reset_c", bus.datapath_out, 16'h0000);
        chk("reset_z", {15'b0, bus.Z_out}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cmp_en = 1;
        test_add();
        idle();
        bus.write = 1; bus.writenum = 5; bus.loadc = 1; bus.ALUop = ALU_SUB;
        step();
        chk("wr_loadc_c", bus.datapath_out, 16'hFFFB);
        rd_reg(2);
        chk("wb_r2", bus.datapath_out, 16'h000F);
        rd_reg(5);
        chk("wb_old_c_r5", bus.datapath_out, 16'h000F);
        wr_imm(3, 16'h000F);
        wr_imm(4, 16'h0005);
        ld(3, 1, 0);
        ld(4, 0, 1);
        op(0, 0, SH_NONE, ALU_SUB, 1, 1, 16'h0);
        chk("sub_c", bus.datapath_out, 16'h000A);
        chk("sub_z0", {15'b0, bus.Z_out}, 16'h0000);
        wr_imm(4, 16'h000F);
        ld(4, 0, 1);
        op(0, 0, SH_NONE, ALU_SUB, 0, 1, 16'h0);
        chk("sub_z1", {15'b0, bus.Z_out}, 16'h0001);
        chk("z_no_loadc_c", bus.datapath_out, 16'h000A);
        wr_imm(6, 16'h1234);
        ld(6, 0, 1);
        op(1, 0, SH_LSL, ALU_ADD, 1, 1, 16'h0);
        chk("lsl_c", bus.datapath_out, 16'h2468);
        chk("lsl_z", {15'b0, bus.Z_out}, 16'h0000);
        op(1, 0, SH_LSR, ALU_ADD, 1, 0, 16'h0);
        chk("lsr_c", bus.datapath_out, 16'h091A);
        op(1, 0, SH_ASR, ALU_ADD, 1, 0, 16'h0);
        chk("asr_pos_c", bus.datapath_out, 16'h091A);
        wr_imm(6, 16'h8000);
        ld(6, 0, 1);
        op(1, 0, SH_ASR, ALU_ADD, 1, 0, 16'h0);
        chk("asr_neg_c", bus.datapath_out, 16'hC000);
        op(1, 0, SH_LSR, ALU_ADD, 1, 0, 16'h0);
        chk("lsr_msb0_c", bus.datapath_out, 16'h4000);
        op(1, 1, SH_NONE, ALU_ADD, 1, 0, 16'hFFF3);
        chk("imm_c", bus.datapath_out, 16'h0013);
        wr_imm(7, 16'h00FF);
        ld(7, 1, 1);
        op(0, 0, SH_NONE, ALU_NOTB, 1, 1, 16'h0);
        chk("notb_c", bus.datapath_out, 16'hFF00);
        wr_imm(5, 16'h0F0F);
        ld(5, 0, 1);
        op(0, 0, SH_NONE, ALU_AND, 1, 1, 16'h0);
        chk("and_c", bus.datapath_out, 16'h000F);
        op(1, 1, SH_NONE, ALU_ADD, 0, 0, 16'h001F);
        chk("hold_c", bus.datapath_out, 16'h000F);
        idle();
        bus.writenum = 7; bus.vsel = 1; bus.datapath_in = 16'hBEEF;
        step();
        rd_reg(7);
        chk("hold_r7", bus.datapath_out, 16'h00FF);
        test_add();
        op(1, 1, SH_NONE, ALU_ADD, 0, 1, 16'h0);
        chk("pre_rst_z", {15'b0, bus.Z_out}, 16'h0001);
        chk("pre_rst_c", bus.datapath_out, 16'h000F);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_c", bus.datapath_out, 16'h0000);
        chk("async_rst_z", {15'b0, bus.Z_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1;
        rd_reg(2);
        chk("rst_r2", bus.datapath_out, 16'h0000);
        ld(1, 0, 1);
        op(1, 0, SH_NONE, ALU_ADD, 1, 1, 16'h0);
        chk("rst_r1_z", {15'b0, bus.Z_out}, 16'h0001);
        idle();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
